// File: rtl/sched_grant_fsm.sv
// sched_grant_fsm: round-robin grant scheduler for one shared datapath unit.
// Issues at most one registered one-hot grant; each grant ends on release
// (done), on request withdrawal, or optionally on a hold-time limit. Every
// grant is followed by a DRAIN cycle and an IDLE cycle before the next award.
//
// Optional feature: define METRON_SCHED_TIMEOUT_EN to enable the hold counter
// and the MAX_HOLD timeout with the preempt pulse. Without it the counter is
// compiled out, preempt is tied low and grants may be held indefinitely.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no grant; award next winner when any request is pending
// GRANT | first cycle of a grant
// HOLD  | grant continuing past its first cycle
// DRAIN | grant dropped; pointer updated; always returns to IDLE
module sched_grant_fsm #(
  parameter int N_REQ    = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           req,
  input  logic                       done,
  output logic [N_REQ-1:0]           grant,
  output logic [$clog2(N_REQ)-1:0]   grant_id,
  output logic                       busy,
  output logic                       preempt,
  output logic [1:0]                 state_o
);

  localparam int IDW = $clog2(N_REQ);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  // Parameter sanity check at elaboration time.
  if (N_REQ < 2 || MAX_HOLD < 2) begin : g_bad_param
    $error("sched_grant_fsm: N_REQ and MAX_HOLD must both be >= 2");
  end

  state_t           state;
  logic [IDW-1:0]   last;
  logic [IDW-1:0]   cand;
  logic [IDW-1:0]   win_id;
  logic             win_found;
  logic [N_REQ-1:0] win_onehot;
  logic             cur_req;
  logic             timeout_hit;
  logic             end_grant;

`ifdef METRON_SCHED_TIMEOUT_EN
  localparam int HW = $clog2(MAX_HOLD + 1);
  logic [HW-1:0] hold_cnt;
  logic          preempt_r;
  logic          timeout_only;

  assign timeout_hit  = (hold_cnt == HW'(MAX_HOLD));
  // Preempt only when the limit is the sole reason the grant ends.
  assign timeout_only = timeout_hit & ~done & cur_req;
  assign preempt      = preempt_r;
`else
  assign timeout_hit = 1'b0;
  assign preempt     = 1'b0;
`endif

  // Round-robin search starting just after the previous winner, wrapping at N_REQ-1.
  always_comb begin
    cand       = last;
    win_id     = '0;
    win_found  = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = (cand == IDW'(N_REQ - 1)) ? '0 : cand + 1'b1;
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
    win_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << win_id;
  end

  // Grant end condition; only the current grantee's request bit matters.
  assign cur_req   = req[grant_id];
  assign end_grant = done | ~cur_req | timeout_hit;

  assign state_o = state;

  // Scheduler state machine with registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      grant    <= '0;
      grant_id <= '0;
      busy     <= 1'b0;
      last     <= IDW'(N_REQ - 1);
`ifdef METRON_SCHED_TIMEOUT_EN
      hold_cnt  <= '0;
      preempt_r <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (win_found) begin
            state    <= GRANT;
            grant    <= win_onehot;
            grant_id <= win_id;
            busy     <= 1'b1;
`ifdef METRON_SCHED_TIMEOUT_EN
            hold_cnt <= HW'(1);
`endif
          end
        end
        GRANT, HOLD: begin
          if (end_grant) begin
            state <= DRAIN;
            grant <= '0;
`ifdef METRON_SCHED_TIMEOUT_EN
            preempt_r <= timeout_only;
`endif
          end else begin
            state <= HOLD;
`ifdef METRON_SCHED_TIMEOUT_EN
            hold_cnt <= hold_cnt + 1'b1;
`endif
          end
        end
        DRAIN: begin
          state <= IDLE;
          busy  <= 1'b0;
          last  <= grant_id;
`ifdef METRON_SCHED_TIMEOUT_EN
          preempt_r <= 1'b0;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sched_grant_fsm.sv
// Directed bench for sched_grant_fsm (N_REQ=4, MAX_HOLD=4).
// Inputs change 1 ns after each rising edge; outputs are checked at that point.
module tb_sched_grant_fsm;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] req   = 4'b0000;
  logic       done  = 1'b0;
  logic [3:0] grant;
  logic [1:0] grant_id;
  logic       busy;
  logic       preempt;
  logic [1:0] state_o;

  int n_cmp = 0;
  int n_bad = 0;

  sched_grant_fsm #(.N_REQ(4), .MAX_HOLD(4)) dut (
    .clock    (clock),
    .reset    (reset),
    .req      (req),
    .done     (done),
    .grant    (grant),
    .grant_id (grant_id),
    .busy     (busy),
    .preempt  (preempt),
    .state_o  (state_o)
  );

  always #5 clock = ~clock;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = 4'b0000;
    done  = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    chk_val("rst_grant",   grant,    0);
    chk_val("rst_id",      grant_id, 0);
    chk_val("rst_busy",    busy,     0);
    chk_val("rst_preempt", preempt,  0);
    chk_val("rst_state",   state_o,  0);

    // done while idle is ignored
    reset = 1'b0;
    done  = 1'b1;
    tick();
    chk_val("idle_done_state", state_o, 0);
    chk_val("idle_done_grant", grant,   0);
    done = 1'b0;

    // Single request with release in the second grant cycle
    req = 4'b0001;
    tick();
    chk_val("single_grant", grant,    4'b0001);
    chk_val("single_id",    grant_id, 0);
    chk_val("single_state", state_o,  1);
    chk_val("single_busy",  busy,     1);
    tick();
    chk_val("single_hold_state", state_o, 2);
    chk_val("single_hold_grant", grant,   4'b0001);
    done = 1'b1;
    tick();
    chk_val("single_drain_grant", grant,   0);
    chk_val("single_drain_state", state_o, 3);
    chk_val("single_drain_busy",  busy,    1);
    chk_val("single_drain_id",    grant_id, 0);
    done = 1'b0;
    req  = 4'b0000;
    tick();
    chk_val("single_idle_state", state_o, 0);
    chk_val("single_idle_busy",  busy,    0);
    chk_val("single_idle_id",    grant_id, 0);

    // Fairness: all requesting, release in each grant's second cycle
    do_reset();
    req = 4'b1111;
    begin
      int order [5] = '{0, 1, 2, 3, 0};
      for (int k = 0; k < 5; k++) begin
        tick();
        chk_val("rr_grant", grant,    32'(4'b0001 << order[k]));
        chk_val("rr_id",    grant_id, order[k]);
        tick();
        done = 1'b1;
        tick();
        chk_val("rr_gap1_grant", grant, 0);
        done = 1'b0;
        tick();
        chk_val("rr_gap2_grant", grant,   0);
        chk_val("rr_gap2_state", state_o, 0);
      end
    end

    // Request drop: requester 1 withdraws in its second grant cycle
    do_reset();
    req = 4'b0010;
    tick();
    chk_val("drop_grant", grant,    4'b0010);
    chk_val("drop_id",    grant_id, 1);
    tick();
    req = 4'b0000;
    tick();
    chk_val("drop_state",   state_o, 3);
    chk_val("drop_grant0",  grant,   0);
    chk_val("drop_preempt", preempt, 0);
    req = 4'b0101;
    tick();
    chk_val("drop_idle", state_o, 0);
    tick();
    chk_val("drop_next_grant", grant,    4'b0100);
    chk_val("drop_next_id",    grant_id, 2);

    // Reset mid-HOLD, with done asserted in the same cycle (ignored)
    tick();
    chk_val("rsthold_state", state_o, 2);
    reset = 1'b1;
    done  = 1'b1;
    tick();
    chk_val("rsthold_grant", grant,    0);
    chk_val("rsthold_state0", state_o, 0);
    chk_val("rsthold_id",    grant_id, 0);
    chk_val("rsthold_busy",  busy,     0);
    reset = 1'b0;
    done  = 1'b0;
    req   = 4'b1001;
    tick();
    chk_val("rsthold_first_grant", grant,    4'b0001);
    chk_val("rsthold_first_id",    grant_id, 0);

`ifdef METRON_SCHED_TIMEOUT_EN
    // Timeout: requester 2 holds with no release
    do_reset();
    req = 4'b0100;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk_val("to_grant", grant, 4'b0100);
      chk_val("to_preempt_lo", preempt, 0);
    end
    tick();
    chk_val("to_drain_grant", grant,   0);
    chk_val("to_preempt",     preempt, 1);
    chk_val("to_drain_state", state_o, 3);
    tick();
    chk_val("to_preempt_clr", preempt, 0);
    chk_val("to_idle_grant",  grant,   0);
    tick();
    chk_val("to_regrant", grant, 4'b0100);
`else
    // No timeout: grant held indefinitely, preempt never asserts
    do_reset();
    req = 4'b0001;
    for (int c = 0; c < 20; c++) begin
      tick();
      chk_val("nto_grant",   grant,   4'b0001);
      chk_val("nto_preempt", preempt, 0);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
